// File: rtl/dmem_debug_port.sv
// -----------------------------------------------------------------------------
// dmem_debug_port
//
// Debug-side master for port B of the data memory. Accepts single-word read,
// single-word write, range fill and range dump commands, drives the
// synchronous-read block RAM through A2/WD2/WE2/RD2 and returns read words (or
// a single acknowledge for write-type commands) on a response channel. It runs
// alongside the CPU pipeline on port A and never touches port A.
//
// Handshakes: both channels use strict valid/ready. A beat transfers on a rising
// clk edge where valid && ready are both high. Once rsp_valid is raised it stays
// high, with rsp_data/rsp_addr/rsp_last unchanged, until that transfer happens
// (reset is the only exception). The command sender must hold cmd_* stable
// until it sees cmd_ready.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready is IDLE && !rst)
//   cmd_op                00 read, 01 write, 10 fill range, 11 dump range
//   cmd_addr              start byte address, bits [1:0] ignored
//   cmd_len               word count for fill/dump (ignored for single ops)
//   cmd_data, cmd_be      write/fill word and byte enables
//   rsp_valid/rsp_ready   response handshake
//   rsp_data              read word, 0 for write/fill acknowledges
//   rsp_addr              word address of rsp_data (start address for acks)
//   rsp_last              final response of the command
//   busy                  high whenever the FSM is not idle
//   A2, WD2, WE2          port-B address, write data, byte write enables
//   RD2                   port-B read data, valid one cycle after A2 sampled
//   dbg_state             current FSM state, for observation only
// -----------------------------------------------------------------------------
module dmem_debug_port #(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [31:0]      cmd_addr,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [31:0]      cmd_data,
   input  logic [3:0]       cmd_be,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic [31:0]      rsp_addr,
   output logic             rsp_last,
   output logic             busy,
   output logic [31:0]      A2,
   output logic [31:0]      WD2,
   output logic [3:0]       WE2,
   input  logic [31:0]      RD2,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WR   = 3'd1,
      S_RD   = 3'd2,
      S_CAP  = 3'd3,
      S_RSP  = 3'd4,
      S_ACK  = 3'd5
   } state_t;

   state_t             state_q;
   logic [LEN_W-1:0]   cnt_q;
   logic [31:0]        start_q;
   logic [31:0]        a2_q;
   logic [31:0]        wd2_q;
   logic [3:0]         we2_q;
   logic               rsp_valid_q;
   logic [31:0]        rsp_data_q;
   logic [31:0]        rsp_addr_q;
   logic               rsp_last_q;
   logic               busy_q;

   // Decoded view of the incoming command.
   logic [31:0]        cmd_addr_al;
   logic               cmd_is_range;
   logic               cmd_is_write;
   logic [LEN_W-1:0]   cmd_cnt;
   logic               cnt_is_one;

   assign cmd_addr_al  = {cmd_addr[31:2], 2'b00};
   assign cmd_is_range = cmd_op[1];
   // 01 write and 10 fill are the write-type ops.
   assign cmd_is_write = cmd_op[1] ^ cmd_op[0];
   assign cmd_cnt      = cmd_is_range ? cmd_len : LEN_W'(1);
   assign cnt_is_one   = (cnt_q == LEN_W'(1));

   // Only output that is not a register: must drop the instant rst rises.
   assign cmd_ready = (state_q == S_IDLE) && !rst;

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_addr  = rsp_addr_q;
   assign rsp_last  = rsp_last_q;
   assign busy      = busy_q;
   assign A2        = a2_q;
   assign WD2       = wd2_q;
   assign WE2       = we2_q;
   assign dbg_state = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         start_q     <= '0;
         a2_q        <= '0;
         wd2_q       <= '0;
         we2_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_addr_q  <= '0;
         rsp_last_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  start_q <= cmd_addr_al;
                  cnt_q   <= cmd_cnt;
                  busy_q  <= 1'b1;
                  if (cmd_cnt == '0) begin
                     // Empty range: acknowledge without any port-B access.
                     rsp_valid_q <= 1'b1;
                     rsp_data_q  <= '0;
                     rsp_addr_q  <= cmd_addr_al;
                     rsp_last_q  <= 1'b1;
                     state_q     <= S_ACK;
                  end else if (cmd_is_write) begin
                     a2_q    <= cmd_addr_al;
                     wd2_q   <= cmd_data;
                     we2_q   <= cmd_be;
                     state_q <= S_WR;
                  end else begin
                     a2_q    <= cmd_addr_al;
                     we2_q   <= '0;
                     state_q <= S_RD;
                  end
               end
            end

            S_WR: begin
               // One word commits at the edge closing each WR cycle.
               cnt_q <= cnt_q - LEN_W'(1);
               a2_q  <= a2_q + 32'd4;
               if (cnt_is_one) begin
                  we2_q       <= '0;
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= '0;
                  rsp_addr_q  <= start_q;
                  rsp_last_q  <= 1'b1;
                  state_q     <= S_ACK;
               end
            end

            S_ACK: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end

            // RAM samples A2 at the edge closing RD; RD2 is valid during CAP.
            S_RD: begin
               state_q <= S_CAP;
            end

            S_CAP: begin
               rsp_valid_q <= 1'b1;
               rsp_data_q  <= RD2;
               rsp_addr_q  <= a2_q;
               rsp_last_q  <= cnt_is_one;
               state_q     <= S_RSP;
            end

            S_RSP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  if (rsp_last_q) begin
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     cnt_q   <= cnt_q - LEN_W'(1);
                     a2_q    <= a2_q + 32'd4;
                     state_q <= S_RD;
                  end
               end
            end

            default: begin
               we2_q       <= '0;
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
